mips_mc_core_p: RTL and testbench
=================================

Name: mips_mc_core_p

Overview:
Parametrised multicycle MIPS core. It combines a width-generic datapath with its main control FSM and adds a variable-latency memory handshake, so the core stalls on slow memory instead of assuming single-cycle access. A single unified memory port serves instruction fetch, loads and stores. The core raises a sticky trap on illegal opcodes. It replaces the fixed 32-bit datapath plus external control pairing at the top of the CPU.

Parameters:
XLEN, 32, datapath/register/PC width; legal values 32 or 64. Instructions are always 32 bits.
RESET_PC, 0, PC value loaded on reset (XLEN bits, word-aligned).

Ports:
ck  in  1  clock, rising edge
rt  in  1  reset, synchronous, active-high
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1
mem_addr  out  XLEN  byte address (PC on fetch, ALUOut on load/store)
mem_wdata  out  XLEN  store data (register B)
mem_rdata  in  XLEN  read data; valid in the cycle mem_ready=1
mem_ready  in  1  memory completes the current request this cycle
trap  out  1  sticky illegal-opcode flag
state_dbg  out  4  current FSM state encoding, for debug

Behaviour:
- Reset: synchronous on rising ck with rt=1. Sets PC=RESET_PC, state=FETCH, IR=0, A/B/ALUOut/MDR=0, all 32 registers=0, trap=0. Outputs after reset: mem_req=0 for that cycle; mem_we=0; mem_addr=RESET_PC; mem_wdata=0. rt has priority over all other events, including mid-handshake; a pending request is abandoned.
- Supported ops: R-type add/sub/and/or/slt (funct 0x20/0x22/0x24/0x25/0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02. Unknown opcode or funct -> TRAP.
- FSM states:
  - FETCH: mem_req=1, mem_we=0, addr=PC. Hold until mem_ready. On mem_ready: IR<=mem_rdata[31:0], PC<=PC+4, go to DECODE.
  - DECODE: A<=rs, B<=rt, ALUOut<=PC+(sext(imm)<<2). Dispatch on opcode.
  - MEMADR: ALUOut<=A+sext(imm). Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, we=0, addr=ALUOut. Hold until mem_ready, then MDR<=mem_rdata and go to MEMWB.
  - MEMWB: rt-field register<=MDR. Go to FETCH.
  - MEMWR: mem_req=1, we=1, addr=ALUOut, wdata=B. Hold until mem_ready, then go to FETCH.
  - EXEC: ALUOut<=A op B. Go to ALUWB.
  - ALUWB: rd-field register<=ALUOut. Go to FETCH.
  - BRANCH: if A==B then PC<=ALUOut. Go to FETCH.
  - ADDIEX: ALUOut<=A+sext(imm). Go to ADDIWB.
  - ADDIWB: rt-field register<=ALUOut. Go to FETCH.
  - JUMP: PC<={PC[XLEN-1:28], instr[25:0], 2'b00}. Go to FETCH.
  - TRAP: trap=1, mem_req=0. Remain in TRAP until rt.
- Handshake: mem_req, mem_we, mem_addr and mem_wdata are held stable while waiting. Zero wait states is legal: mem_ready=1 in the first request cycle completes it. mem_ready is ignored when mem_req=0.
- Latencies with zero wait: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3. Each wait cycle adds 1.
- Arithmetic: XLEN-bit wrap-around with no overflow trap. slt is a signed compare. sext extends imm16 to XLEN.
- Register 0: reads return 0; writes are discarded.
- Simultaneous read and write of the same register in one cycle: the read returns the old value.

Decomposition:
- Package mips_mc_pkg: opcode and funct localparams; state enum (4-bit); ALU control enum (3-bit: AND, OR, ADD, SUB, SLT).
- One sub-module, regfile_p #(XLEN): 32 x XLEN, 2 read ports, 1 write port, synchronous write, register 0 hardwired to zero.
- ALU, muxes and FSM live inline in the core.

Test Plan:
- Reset: rt=1 for 2 cycles with RESET_PC=0x100 -> mem_addr=0x100, mem_req=0 during reset, FETCH with mem_req=1 the cycle after rt falls.
- Zero-wait program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x40($0); lw $4,0x40($0) -> store of 12 to 0x40, $4=12, total 21 cycles.
- Wait states: mem_ready delayed 3 cycles on every access for lw -> 11 cycles; mem_addr and mem_we stable throughout each wait.
- Branching: beq $1,$1,-1 loops with PC constant; j to 0x0040_0000 -> next fetch addr 0x0040_0000; beq not-taken -> PC+4.
- Illegal opcode 0x3F -> trap=1, mem_req=0 indefinitely; rt clears trap and refetches RESET_PC.
- XLEN=64: addi $1,$0,-1; slt $2,$1,$0 -> $1=0xFFFF_FFFF_FFFF_FFFF, $2=1. Write to $0 reads back 0. Reset asserted mid-lw wait -> request dropped and state returns to FETCH.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the parametrised multicycle MIPS core: opcodes,
// function codes, FSM state encoding and ALU control.
package mips_mc_pkg;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FunctAdd = 6'h20;
    localparam logic [5:0] FunctSub = 6'h22;
    localparam logic [5:0] FunctAnd = 6'h24;
    localparam logic [5:0] FunctOr  = 6'h25;
    localparam logic [5:0] FunctSlt = 6'h2A;

    // Main control FSM states; the encoding is exported on state_dbg
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StTrap   = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        AluAnd = 3'b000,
        AluOr  = 3'b001,
        AluAdd = 3'b010,
        AluSub = 3'b110,
        AluSlt = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } funct_dec_t;

    // Map an R-type funct field to an ALU operation; valid=0 for unsupported codes
    function automatic funct_dec_t decode_funct(input logic [5:0] funct);
        funct_dec_t dec;
        dec.valid = 1'b1;
        dec.op    = AluAdd;
        unique case (funct)
            FunctAdd: dec.op = AluAdd;
            FunctSub: dec.op = AluSub;
            FunctAnd: dec.op = AluAnd;
            FunctOr:  dec.op = AluOr;
            FunctSlt: dec.op = AluSlt;
            default:  dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/regfile_p.sv
// 32 x XLEN register file: two combinational read ports, one synchronous
// write port, register 0 reads as zero and ignores writes.
module regfile_p #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [32];

    // Synchronous reset clears every register; writes to $0 are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded
    always_comb begin
        rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];
    end

endmodule

// File: rtl/mips_mc_core_p.sv
// Multicycle MIPS core with a width-generic datapath and a single unified
// memory port using a req/ready handshake, so every access may stall.
module mips_mc_core_p
    import mips_mc_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            ck,
    input  logic            rt,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            trap,
    output logic [3:0]      state_dbg
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] mdr_q, mdr_d;

    // Instruction fields
    logic [5:0]      opcode;
    logic [4:0]      rs_idx, rt_idx, rd_idx;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm_sext, imm_sext_sh2;
    funct_dec_t      funct_dec;

    assign opcode       = ir_q[31:26];
    assign rs_idx       = ir_q[25:21];
    assign rt_idx       = ir_q[20:16];
    assign rd_idx       = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign imm_sext     = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_sext_sh2 = imm_sext << 2;
    assign funct_dec    = decode_funct(funct);

    // Register file
    logic [XLEN-1:0] rs_data, rt_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    regfile_p #(
        .XLEN(XLEN)
    ) u_regfile (
        .clk_i    (ck),
        .rst_i    (rt),
        .raddr_a_i(rs_idx),
        .rdata_a_o(rs_data),
        .raddr_b_i(rt_idx),
        .rdata_b_o(rt_data),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata)
    );

    // ALU
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    alu_op_e         alu_op;

    // ALU operand selection: PC+4 in fetch, branch target in decode,
    // effective address / addi in MEMADR / ADDIEX, register op in EXEC
    always_comb begin
        alu_a  = pc_q;
        alu_b  = XLEN'(4);
        alu_op = AluAdd;
        unique case (state_q)
            StDecode: alu_b = imm_sext_sh2;
            StMemAdr, StAddiEx: begin
                alu_a = a_q;
                alu_b = imm_sext;
            end
            StExec: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = funct_dec.op;
            end
            default: ;
        endcase
    end

    // ALU function, wrap-around arithmetic with signed set-less-than
    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            AluAnd:  alu_res = alu_a & alu_b;
            AluOr:   alu_res = alu_a | alu_b;
            AluAdd:  alu_res = alu_a + alu_b;
            AluSub:  alu_res = alu_a - alu_b;
            AluSlt:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_res = '0;
        endcase
    end

    // FSM next state, datapath register updates and memory port drive
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = rt_idx;
        rf_wdata  = alu_out_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = alu_res;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d       = rs_data;
                b_d       = rt_data;
                alu_out_d = alu_res;
                unique case (opcode)
                    OpRtype:   state_d = funct_dec.valid ? StExec : StTrap;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:     state_d = StBranch;
                    OpAddi:    state_d = StAddiEx;
                    OpJ:       state_d = StJump;
                    default:   state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_out_d = alu_res;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req  = 1'b1;
                mem_addr = alu_out_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                rf_we    = 1'b1;
                rf_waddr = rt_idx;
                rf_wdata = mdr_q;
                state_d  = StFetch;
            end
            StMemWr: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = alu_out_q;
                mem_wdata = b_q;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExec: begin
                alu_out_d = alu_res;
                state_d   = StAluWb;
            end
            StAluWb: begin
                rf_we    = 1'b1;
                rf_waddr = rd_idx;
                state_d  = StFetch;
            end
            StBranch: begin
                if (a_q == b_q) begin
                    pc_d = alu_out_q;
                end
                state_d = StFetch;
            end
            StAddiEx: begin
                alu_out_d = alu_res;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                rf_we    = 1'b1;
                rf_waddr = rt_idx;
                state_d  = StFetch;
            end
            StJump: begin
                pc_d    = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                state_d = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // Reset abandons any pending request and parks the port at RESET_PC
        if (rt) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = RESET_PC;
            mem_wdata = '0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge ck) begin
        if (rt) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // TRAP is only left through reset, so the state itself is the sticky flag
    assign trap      = (state_q == StTrap);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_mc_core_p.sv
// Directed bench for mips_mc_core_p: a 32-bit core driven by tables and
// hand-written sequences, plus a 64-bit core running one fixed program.
module tb_mips_mc_core_p;
    import mips_mc_pkg::*;

    logic ck = 1'b0;
    initial forever #5 ck = ~ck;

    int n_checks = 0;
    int n_fail   = 0;

    // 32-bit core
    logic        rt_a = 1'b1;
    logic        req_a, we_a, trap_a;
    logic [31:0] addr_a, wdata_a;
    logic [31:0] rdata_a = '0;
    logic        ready_a = 1'b0;
    logic [3:0]  dbg_a;

    // 64-bit core
    logic        rt_b = 1'b1;
    logic        req_b, we_b, trap_b;
    logic [63:0] addr_b, wdata_b;
    logic [63:0] rdata_b = '0;
    logic        ready_b = 1'b0;
    logic [3:0]  dbg_b;

    mips_mc_core_p #(.XLEN(32), .RESET_PC(32'h100)) u_dut_a (
        .ck(ck), .rt(rt_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ready(ready_a),
        .trap(trap_a), .state_dbg(dbg_a)
    );

    mips_mc_core_p #(.XLEN(64), .RESET_PC(64'h100)) u_dut_b (
        .ck(ck), .rt(rt_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ready(ready_b),
        .trap(trap_b), .state_dbg(dbg_b)
    );

    logic [31:0] mem_a [1024];
    logic [63:0] mem_b [1024];
    logic [63:0] st_addr_a[$], st_data_a[$], st_addr_b[$], st_data_b[$];
    int          wait_a = 0;
    int          cnt_a = 0, cnt_b = 0;
    logic        pend_a = 1'b0;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder for core A: wait_a stall cycles per request,
    // and checks the request is held stable across every stall
    always @(negedge ck) begin
        if (ready_a) cnt_a = 0;
        if (pend_a && !rt_a) begin
            n_checks++;
            if (!(req_a && addr_a == hold_addr && we_a == hold_we && wdata_a == hold_wdata)) begin
                n_fail++;
                $display("FAIL hold_stable: got req=%0b addr=0x%0h we=%0b, expected req=1 addr=0x%0h we=%0b",
                         req_a, addr_a, we_a, hold_addr, hold_we);
            end
        end
        pend_a = 1'b0;
        if (rt_a || !req_a) begin
            ready_a = 1'b0;
            cnt_a   = 0;
        end else if (cnt_a >= wait_a) begin
            ready_a = 1'b1;
            rdata_a = mem_a[addr_a[11:2]];
            if (we_a) begin
                mem_a[addr_a[11:2]] = wdata_a;
                st_addr_a.push_back(64'(addr_a));
                st_data_a.push_back(64'(wdata_a));
            end
        end else begin
            ready_a    = 1'b0;
            cnt_a++;
            pend_a     = 1'b1;
            hold_addr  = addr_a;
            hold_we    = we_a;
            hold_wdata = wdata_a;
        end
    end

    // Memory responder for core B: zero wait states
    always @(negedge ck) begin
        if (rt_b || !req_b) begin
            ready_b = 1'b0;
        end else begin
            ready_b = 1'b1;
            rdata_b = mem_b[addr_b[11:2]];
            if (we_b) begin
                mem_b[addr_b[11:2]] = wdata_b;
                st_addr_b.push_back(addr_b);
                st_data_b.push_back(wdata_b);
            end
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [15:0] imm);
        return {op, rs_f, rt_f, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                          input logic [4:0] rd_f, input logic [5:0] fn);
        return {6'h00, rs_f, rt_f, rd_f, 5'd0, fn};
    endfunction

    // Cycles (1 = next falling edge) until core A issues the given request
    task automatic wait_req(input logic [31:0] addr, input logic we, input int max,
                            output int cyc);
        cyc = -1;
        for (int n = 1; n <= max; n++) begin
            @(negedge ck);
            if (req_a && (we_a == we) && (addr_a == addr)) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic hold_reset_a();
        @(posedge ck);
        #1 rt_a = 1'b1;
        st_addr_a.delete();
        st_data_a.delete();
        for (int i = 0; i < 1024; i++) mem_a[i] = '0;
    endtask

    task automatic release_a();
        repeat (2) @(posedge ck);
        #1 rt_a = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [5:0]  fn;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[8];
    int   cyc;
    int   bad;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{name: "add",      v1: 16'd5,     v2: 16'd7,     fn: 6'h20, res: 32'h0000_000C};
        vecs[1] = '{name: "sub_neg",  v1: 16'd5,     v2: 16'd7,     fn: 6'h22, res: 32'hFFFF_FFFE};
        vecs[2] = '{name: "and",      v1: 16'h000C,  v2: 16'h000A,  fn: 6'h24, res: 32'h0000_0008};
        vecs[3] = '{name: "or",       v1: 16'h000C,  v2: 16'h000A,  fn: 6'h25, res: 32'h0000_000E};
        vecs[4] = '{name: "slt_true", v1: 16'hFFFD,  v2: 16'd2,     fn: 6'h2A, res: 32'h0000_0001};
        vecs[5] = '{name: "slt_fals", v1: 16'd2,     v2: 16'hFFFD,  fn: 6'h2A, res: 32'h0000_0000};
        vecs[6] = '{name: "sub_min",  v1: 16'h8000,  v2: 16'd1,     fn: 6'h22, res: 32'hFFFF_7FFF};
        vecs[7] = '{name: "add_wrap", v1: 16'hFFFF,  v2: 16'd1,     fn: 6'h20, res: 32'h0000_0000};

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        // Core A: zero-wait store/load program at 0x100
        mem_a[32'h40] = itype(6'h08, 5'd0, 5'd1, 16'd5);
        mem_a[32'h41] = itype(6'h08, 5'd0, 5'd2, 16'd7);
        mem_a[32'h42] = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        mem_a[32'h43] = itype(6'h2B, 5'd0, 5'd3, 16'h0040);
        mem_a[32'h44] = itype(6'h23, 5'd0, 5'd4, 16'h0040);
        mem_a[32'h45] = itype(6'h2B, 5'd0, 5'd4, 16'h0044);
        // Core B: 64-bit sign extension, signed slt, write to $0
        mem_b[32'h40] = 64'(itype(6'h08, 5'd0, 5'd1, 16'hFFFF));
        mem_b[32'h41] = 64'(rtype(5'd1, 5'd0, 5'd2, 6'h2A));
        mem_b[32'h42] = 64'(itype(6'h08, 5'd0, 5'd0, 16'd9));
        mem_b[32'h43] = 64'(itype(6'h2B, 5'd0, 5'd1, 16'h0040));
        mem_b[32'h44] = 64'(itype(6'h2B, 5'd0, 5'd2, 16'h0048));
        mem_b[32'h45] = 64'(itype(6'h2B, 5'd0, 5'd0, 16'h0050));

        // Reset state, sampled while rt is still high
        @(negedge ck);
        check("rst_req", 64'(req_a), 64'h0);
        check("rst_we", 64'(we_a), 64'h0);
        check("rst_addr", 64'(addr_a), 64'h100);
        check("rst_wdata", 64'(wdata_a), 64'h0);
        check("rst_trap", 64'(trap_a), 64'h0);
        check("rst_state", 64'(dbg_a), 64'(StFetch));
        check("rst_req_b", 64'(req_b), 64'h0);
        check("rst_addr_b", addr_b, 64'h100);
        @(posedge ck);
        #1;
        rt_a = 1'b0;
        rt_b = 1'b0;

        // Zero-wait program: 21 cycles for five instructions
        wait_req(32'h100, 1'b0, 1, cyc);
        check("first_fetch", 64'(cyc), 64'd1);
        wait_req(32'h114, 1'b0, 40, cyc);
        check("prog_cycles", 64'(cyc), 64'd21);
        wait_req(32'h118, 1'b0, 10, cyc);
        check("sw_cycles", 64'(cyc), 64'd4);
        check("prog_nstores", 64'(st_addr_a.size()), 64'd2);
        if (st_addr_a.size() == 2) begin
            check("sw_addr", st_addr_a[0], 64'h40);
            check("sw_data", st_data_a[0], 64'd12);
            check("lw_addr", st_addr_a[1], 64'h44);
            check("lw_data", st_data_a[1], 64'd12);
        end

        // Table: addi $1; addi $2; op $3,$1,$2; sw $3,0x40($0)
        for (int i = 0; i < 8; i++) begin
            hold_reset_a();
            mem_a[32'h40] = itype(6'h08, 5'd0, 5'd1, vecs[i].v1);
            mem_a[32'h41] = itype(6'h08, 5'd0, 5'd2, vecs[i].v2);
            mem_a[32'h42] = rtype(5'd1, 5'd2, 5'd3, vecs[i].fn);
            mem_a[32'h43] = itype(6'h2B, 5'd0, 5'd3, 16'h0040);
            release_a();
            wait_req(32'h100, 1'b0, 1, cyc);
            wait_req(32'h110, 1'b0, 40, cyc);
            check($sformatf("%s_cycles", vecs[i].name), 64'(cyc), 64'd16);
            check($sformatf("%s_nst", vecs[i].name), 64'(st_data_a.size()), 64'd1);
            check($sformatf("%s_data", vecs[i].name),
                  (st_data_a.size() != 0) ? st_data_a[0] : 64'hDEAD_BEEF_DEAD_BEEF,
                  64'(vecs[i].res));
        end

        // Three wait states per access: lw 11 cycles, sw 10 cycles
        hold_reset_a();
        wait_a = 3;
        mem_a[32'h10] = 32'h1234_5678;
        mem_a[32'h40] = itype(6'h23, 5'd0, 5'd5, 16'h0040);
        mem_a[32'h41] = itype(6'h2B, 5'd0, 5'd5, 16'h0044);
        release_a();
        wait_req(32'h100, 1'b0, 1, cyc);
        wait_req(32'h104, 1'b0, 30, cyc);
        check("lw_wait_cycles", 64'(cyc), 64'd11);
        wait_req(32'h108, 1'b0, 30, cyc);
        check("sw_wait_cycles", 64'(cyc), 64'd10);
        check("wait_st_data", (st_data_a.size() != 0) ? st_data_a[0] : 64'hDEAD, 64'h1234_5678);

        // beq $1,$1,-1 spins at the same PC
        hold_reset_a();
        wait_a = 0;
        mem_a[32'h40] = itype(6'h08, 5'd0, 5'd1, 16'd3);
        mem_a[32'h41] = itype(6'h04, 5'd1, 5'd1, 16'hFFFF);
        release_a();
        wait_req(32'h100, 1'b0, 1, cyc);
        wait_req(32'h104, 1'b0, 10, cyc);
        check("loop_enter", 64'(cyc), 64'd4);
        wait_req(32'h104, 1'b0, 10, cyc);
        check("loop_iter1", 64'(cyc), 64'd3);
        wait_req(32'h104, 1'b0, 10, cyc);
        check("loop_iter2", 64'(cyc), 64'd3);

        // beq not taken falls through, then j 0x0040_0000
        hold_reset_a();
        mem_a[32'h40] = itype(6'h08, 5'd0, 5'd1, 16'd3);
        mem_a[32'h41] = itype(6'h04, 5'd1, 5'd0, 16'd5);
        mem_a[32'h42] = {6'h02, 26'h010_0000};
        release_a();
        wait_req(32'h100, 1'b0, 1, cyc);
        wait_req(32'h104, 1'b0, 10, cyc);
        wait_req(32'h108, 1'b0, 10, cyc);
        check("beq_nt", 64'(cyc), 64'd3);
        wait_req(32'h0040_0000, 1'b0, 10, cyc);
        check("jump", 64'(cyc), 64'd3);

        // Illegal opcode 0x3F traps and stays quiet until reset
        hold_reset_a();
        mem_a[32'h40] = 32'hFC00_0000;
        release_a();
        wait_req(32'h100, 1'b0, 1, cyc);
        repeat (2) @(negedge ck);
        check("ill_state", 64'(dbg_a), 64'(StTrap));
        check("ill_trap", 64'(trap_a), 64'h1);
        check("ill_req", 64'(req_a), 64'h0);
        bad = 0;
        repeat (10) begin
            @(negedge ck);
            if (!trap_a || req_a) bad++;
        end
        check("ill_sticky", 64'(bad), 64'd0);
        hold_reset_a();
        @(negedge ck);
        @(negedge ck);
        check("trap_clr", 64'(trap_a), 64'h0);
        mem_a[32'h40] = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        release_a();
        wait_req(32'h100, 1'b0, 1, cyc);
        check("refetch", 64'(cyc), 64'd1);
        repeat (2) @(negedge ck);
        check("bad_funct_trap", 64'(trap_a), 64'h1);

        // Reset in the middle of a stalled load
        hold_reset_a();
        wait_a = 5;
        mem_a[32'h40] = itype(6'h23, 5'd0, 5'd5, 16'h0040);
        release_a();
        wait_req(32'h40, 1'b0, 20, cyc);
        check("midlw_req", 64'(cyc), 64'd9);
        @(posedge ck);
        #1 rt_a = 1'b1;
        @(negedge ck);
        check("midlw_drop", 64'(req_a), 64'h0);
        @(negedge ck);
        check("midlw_state", 64'(dbg_a), 64'(StFetch));
        check("midlw_addr", 64'(addr_a), 64'h100);
        @(posedge ck);
        #1 rt_a = 1'b0;
        @(negedge ck);
        check("midlw_refetch", 64'(req_a), 64'h1);
        check("midlw_refetch_addr", 64'(addr_a), 64'h100);
        check("midlw_nst", 64'(st_addr_a.size()), 64'd0);

        // Core B results (its program finished long ago)
        check("b64_nst", 64'(st_data_b.size()), 64'd3);
        if (st_data_b.size() == 3) begin
            check("b64_addi_neg", st_data_b[0], 64'hFFFF_FFFF_FFFF_FFFF);
            check("b64_slt", st_data_b[1], 64'h1);
            check("b64_r0", st_data_b[2], 64'h0);
            check("b64_r0_addr", st_addr_b[2], 64'h50);
        end
        check("b64_trap", 64'(trap_b), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
